lut_neuron_cfg_writer: RTL and testbench
========================================

Name: lut_neuron_cfg_writer

Overview:
Runtime-programmable LUT neuron: the writer side of a neuron truth table, replacing a fixed ROM with a table loaded over a valid/ready config stream.
- Config beats fill a shadow table; the completed load commits atomically into the active table.
- Active table answers registered evaluation lookups.
- Sits beside generated layer neurons so the on-chip model can be reprogrammed without re-synthesis.

Parameters:
IN_BITS, 6, neuron fan-in bits; table depth = 2**IN_BITS
OUT_BITS, 1, output bits per table entry
CFG_W, 8, config beat width; must divide 2**IN_BITS*OUT_BITS and be a multiple of OUT_BITS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_start  in  1  pulse: begin new load (clears shadow write pointer)
cfg_valid  in  1  config beat valid
cfg_ready  out  1  config beat accepted when cfg_valid&cfg_ready
cfg_data  in  CFG_W  config beat; bit j of beat k = table bit k*CFG_W+j
cfg_done  out  1  one-cycle pulse on commit
cfg_error  out  1  sticky: load aborted; cleared by next successful commit
tbl_loaded  out  1  active table has been committed at least once since reset
eval_valid  in  1  lookup request
eval_in  in  IN_BITS  lookup address
eval_out  out  OUT_BITS  table entry eval_in (entry bits e*OUT_BITS +: OUT_BITS)
eval_out_valid  out  1  eval_valid delayed by one cycle

Behaviour:
- Reset: state IDLE, beat counter 0, shadow and active tables all 0, cfg_ready=0, cfg_done=0, cfg_error=0, tbl_loaded=0, eval_out=0, eval_out_valid=0.
- BEATS = 2**IN_BITS*OUT_BITS/CFG_W (default 8).
- IDLE:
  - cfg_ready=0; cfg_valid ignored.
  - cfg_start -> LOAD, counter=0.
- LOAD:
  - cfg_ready=1. Each handshake writes cfg_data into shadow slice [counter*CFG_W +: CFG_W], then counter++.
  - Handshake with counter==BEATS-1 -> COMMIT.
  - cfg_start in LOAD: restart. Counter=0, set cfg_error; a beat presented in that same cycle is NOT accepted (cfg_ready=0 that cycle).
- COMMIT (one cycle): cfg_ready=0, active<=shadow, cfg_done=1 next cycle, cfg_error<=0, tbl_loaded<=1; -> IDLE.
- cfg_start in COMMIT: ignored; commit completes.
- Eval:
  - Registered, latency 1. eval_out <= active[eval_in] when eval_valid, else holds.
  - eval_out_valid <= eval_valid.
  - Lookup in the COMMIT cycle reads the OLD table; the first lookup issued the following cycle reads the new table.
  - Eval is never stalled by loading.
- Partial load: shadow is never visible to eval. Active table changes only in COMMIT.
- Reset mid-load: everything returns to reset values, including active table.

Optional Feature:
CFG_PARITY_EN
- Defined: adds input port cfg_parity (1 bit, even parity over cfg_data, sampled with the beat).
  - Mismatch on an accepted beat: abort load, set cfg_error, -> IDLE, no commit, active table untouched.
- Undefined: no port, no check.

Decomposition:
- Package lut_cfg_pkg:
  - state enum {IDLE, LOAD, COMMIT}
  - localparam functions TBL_BITS(IN_BITS,OUT_BITS) and BEATS(...)
  - counter width via $clog2(BEATS)
- Sub-module lut_table_bank: shadow register, active register, beat-slice write, commit copy, registered read mux.
- Top holds the FSM, counter and flags.

Test Plan:
- Reset value check: assert rst mid-operation -> all outputs 0 within same cycle, eval of any address returns 0 one cycle after eval_valid.
- Full load: cfg_start, beats 00,00,20,20,00,00,20,20 back-to-back -> cfg_done pulse once, tbl_loaded=1. Then eval 21, 29, 53, 61 each -> 1; eval 22, 0, 63 -> 0, each one cycle after request.
- Backpressure/gaps: same load with cfg_valid toggling every other cycle -> identical table, cfg_ready low in IDLE.
- Abort: load 3 beats, pulse cfg_start, load 8 beats all FF -> cfg_error 1 after abort, cleared at commit; eval 5 -> 1.
- Commit race: with table of all 0 active, load all FF; eval 7 issued in COMMIT cycle -> 0, eval 7 next cycle -> 1.
- CFG_PARITY_EN: beat 3 with wrong parity -> cfg_error=1, state IDLE, no cfg_done, previous table still returned by eval.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg
// Shared types and sizing helpers for the runtime-programmable LUT neuron
// configuration writer (lut_neuron_cfg_writer and lut_table_bank).
//   state_t  : writer FSM states (IDLE, LOAD, COMMIT)
//   TBL_BITS : total truth-table bits for a given fan-in / output width
//   BEATS    : number of config beats needed to fill one table
//   CNT_W    : width of the beat counter (never narrower than 1 bit)
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  function automatic int TBL_BITS(input int in_bits, input int out_bits);
    return (1 << in_bits) * out_bits;
  endfunction

  function automatic int BEATS(input int in_bits, input int out_bits, input int cfg_w);
    return TBL_BITS(in_bits, out_bits) / cfg_w;
  endfunction

  // A single-beat table still needs a 1-bit counter to index with.
  function automatic int CNT_W(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/lut_table_bank.sv
// lut_table_bank
// Storage for the LUT neuron truth table: a shadow copy filled beat by beat
// and an active copy that evaluation reads. The shadow is never visible to
// evaluation; the active copy only changes on a commit.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   beat_we         : write beat_data into shadow slice beat_idx
//   beat_idx        : beat slot, slice [beat_idx*CFG_W +: CFG_W]
//   beat_data       : config beat payload
//   commit          : copy shadow into active at the next edge
//   eval_valid      : lookup request
//   eval_in         : lookup address
//   eval_out        : registered table entry, holds when no request
//   eval_out_valid  : eval_valid delayed by one cycle
module lut_table_bank
  import lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int CFG_W    = 8,
  parameter int CNT_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                beat_we,
  input  logic [CNT_BITS-1:0] beat_idx,
  input  logic [CFG_W-1:0]    beat_data,
  input  logic                commit,
  input  logic                eval_valid,
  input  logic [IN_BITS-1:0]  eval_in,
  output logic [OUT_BITS-1:0] eval_out,
  output logic                eval_out_valid
);

  localparam int TBITS = TBL_BITS(IN_BITS, OUT_BITS);

  logic [TBITS-1:0]    shadow_q, shadow_d;
  logic [TBITS-1:0]    active_q, active_d;
  logic [OUT_BITS-1:0] eval_out_q, eval_out_d;
  logic                eval_out_valid_q, eval_out_valid_d;

  // A lookup in the commit cycle reads active_q, i.e. the old table; the
  // new table is visible to requests issued from the following cycle on.
  always_comb begin
    shadow_d         = shadow_q;
    active_d         = active_q;
    eval_out_d       = eval_out_q;
    eval_out_valid_d = eval_valid;
    if (beat_we) begin
      shadow_d[beat_idx * CFG_W +: CFG_W] = beat_data;
    end
    if (commit) begin
      active_d = shadow_q;
    end
    if (eval_valid) begin
      eval_out_d = active_q[eval_in * OUT_BITS +: OUT_BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q         <= '0;
      active_q         <= '0;
      eval_out_q       <= '0;
      eval_out_valid_q <= 1'b0;
    end else begin
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      eval_out_q       <= eval_out_d;
      eval_out_valid_q <= eval_out_valid_d;
    end
  end

  assign eval_out       = eval_out_q;
  assign eval_out_valid = eval_out_valid_q;

endmodule

// File: rtl/lut_neuron_cfg_writer.sv
// lut_neuron_cfg_writer
// Writer side of a runtime-programmable LUT neuron. Config beats arrive over
// a valid/ready stream into a shadow table; once all beats are in, the table
// commits atomically into the active table that answers lookups.
// Optional feature macro: CFG_PARITY_EN adds cfg_parity (even parity over
// cfg_data); a bad beat aborts the load without touching the active table.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   cfg_start       : pulse, begin (or restart) a load
//   cfg_valid/ready : config beat handshake
//   cfg_data        : beat k bit j = table bit k*CFG_W+j
//   cfg_parity      : (CFG_PARITY_EN only) even parity of cfg_data
//   cfg_done        : one-cycle pulse after a commit
//   cfg_error       : sticky abort flag, cleared by next commit
//   tbl_loaded      : active table committed at least once since reset
//   eval_valid/in   : lookup request and address
//   eval_out/valid  : registered lookup result, latency 1
module lut_neuron_cfg_writer
  import lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int CFG_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
`ifdef CFG_PARITY_EN
  input  logic                cfg_parity,
`endif
  output logic                cfg_done,
  output logic                cfg_error,
  output logic                tbl_loaded,
  input  logic                eval_valid,
  input  logic [IN_BITS-1:0]  eval_in,
  output logic [OUT_BITS-1:0] eval_out,
  output logic                eval_out_valid
);

  localparam int NUM_BEATS = BEATS(IN_BITS, OUT_BITS, CFG_W);
  localparam int CNT_BITS  = CNT_W(NUM_BEATS);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                loaded_q, loaded_d;
  logic                done_q, done_d;
  logic                ready;
  logic                beat_we;
  logic                commit;
  logic                parity_bad;

`ifdef CFG_PARITY_EN
  assign parity_bad = (cfg_parity != (^cfg_data));
`else
  assign parity_bad = 1'b0;
`endif

  // Next-state and handshake logic. A cfg_start seen in LOAD restarts the
  // load and deliberately refuses any beat presented in that same cycle, so
  // the first beat of the new load always lands in slot 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    ready    = 1'b0;
    beat_we  = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
          err_d = 1'b1;
        end else begin
          ready = 1'b1;
          if (cfg_valid) begin
            if (parity_bad) begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              beat_we = 1'b1;
              cnt_d   = cnt_q + 1'b1;
              if (cnt_q == CNT_BITS'(NUM_BEATS - 1)) begin
                state_d = COMMIT;
              end
            end
          end
        end
      end
      COMMIT: begin
        commit   = 1'b1;
        done_d   = 1'b1;
        err_d    = 1'b0;
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready  = ready;
  assign cfg_done   = done_q;
  assign cfg_error  = err_q;
  assign tbl_loaded = loaded_q;

  lut_table_bank #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .CFG_W   (CFG_W),
    .CNT_BITS(CNT_BITS)
  ) u_bank (
    .clk           (clk),
    .rst           (rst),
    .beat_we       (beat_we),
    .beat_idx      (cnt_q),
    .beat_data     (cfg_data),
    .commit        (commit),
    .eval_valid    (eval_valid),
    .eval_in       (eval_in),
    .eval_out      (eval_out),
    .eval_out_valid(eval_out_valid)
  );

endmodule

// File: tb/tb_lut_neuron_cfg_writer.sv
// tb_lut_neuron_cfg_writer
// Directed bench for lut_neuron_cfg_writer in its default configuration
// (IN_BITS=6, OUT_BITS=1, CFG_W=8, eight beats per table). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_lut_neuron_cfg_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_done;
  logic       cfg_error;
  logic       tbl_loaded;
  logic       eval_valid;
  logic [5:0] eval_in;
  logic [0:0] eval_out;
  logic       eval_out_valid;

  int totalCount = 0;
  int badCount   = 0;

  // Table A: ones only at entries 21, 29, 53, 61 (beats 00,00,20,20,00,00,20,20).
  localparam logic [63:0] TABLE_A   = 64'h2020_0000_2020_0000;
  localparam logic [63:0] TABLE_ONE = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  lut_neuron_cfg_writer dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_data      (cfg_data),
    .cfg_done      (cfg_done),
    .cfg_error     (cfg_error),
    .tbl_loaded    (tbl_loaded),
    .eval_valid    (eval_valid),
    .eval_in       (eval_in),
    .eval_out      (eval_out),
    .eval_out_valid(eval_out_valid)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    if (obs !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at a falling edge and wait for the next one.
  task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] data,
                               input logic ev, input logic [5:0] ein);
    cfg_start  = start;
    cfg_valid  = valid;
    cfg_data   = data;
    eval_valid = ev;
    eval_in    = ein;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0);
    rst = 1'b0;
  endtask

  // Start pulse (with a junk beat offered, which must be refused) followed by
  // all eight beats. With gaps, cfg_valid drops every other cycle and junk data
  // is driven while invalid. Returns in the COMMIT cycle.
  task automatic loadTable(input string tag, input logic [63:0] img, input bit gaps);
    int   k;
    int   guard;
    logic hs;
    k     = 0;
    guard = 0;
    cfg_start  = 1'b1;
    cfg_valid  = 1'b1;
    cfg_data   = 8'h5A;
    eval_valid = 1'b0;
    #1;
    checkOutput({tag, "_ready_on_start"}, 32'(cfg_ready), 32'd0);
    @(negedge clk);
    cfg_start = 1'b0;
    while (k < 8 && guard < 64) begin
      cfg_valid = gaps ? ((guard % 2) == 0) : 1'b1;
      cfg_data  = cfg_valid ? img[k*8 +: 8] : 8'hC3;
      #1;
      hs = cfg_valid && cfg_ready;
      @(negedge clk);
      if (hs) k++;
      guard++;
    end
    cfg_valid = 1'b0;
    checkOutput({tag, "_beats_accepted"}, 32'(k), 32'd8);
  endtask

  // Lookup issued in the COMMIT cycle: must see the old entry, and the
  // commit side effects must be visible right after.
  task automatic commitStep(input string tag, input logic [5:0] addr, input logic expOld);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, addr);
    checkOutput({tag, "_commit_cycle_eval"}, 32'(eval_out), 32'(expOld));
    checkOutput({tag, "_done_pulse"}, 32'(cfg_done), 32'd1);
    checkOutput({tag, "_error_cleared"}, 32'(cfg_error), 32'd0);
    checkOutput({tag, "_loaded"}, 32'(tbl_loaded), 32'd1);
  endtask

  task automatic evalCheck(input string tag, input logic [5:0] addr, input logic exp);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, addr);
    checkOutput({tag, "_out"}, 32'(eval_out), 32'(exp));
    checkOutput({tag, "_valid"}, 32'(eval_out_valid), 32'd1);
  endtask

  initial begin
    cfg_start  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = 8'h00;
    eval_valid = 1'b0;
    eval_in    = 6'd0;
    rst        = 1'b1;
    @(negedge clk);
    doReset();

    // Reset state.
    checkOutput("rst_ready", 32'(cfg_ready), 32'd0);
    checkOutput("rst_done", 32'(cfg_done), 32'd0);
    checkOutput("rst_error", 32'(cfg_error), 32'd0);
    checkOutput("rst_loaded", 32'(tbl_loaded), 32'd0);
    checkOutput("rst_eval_valid", 32'(eval_out_valid), 32'd0);
    evalCheck("rst_eval_21", 6'd21, 1'b0);

    // Full back-to-back load of table A.
    loadTable("full", TABLE_A, 1'b0);
    commitStep("full", 6'd21, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0);
    checkOutput("full_done_one_cycle", 32'(cfg_done), 32'd0);
    checkOutput("full_eval_hold", 32'(eval_out), 32'd0);
    checkOutput("full_eval_valid_low", 32'(eval_out_valid), 32'd0);
    evalCheck("a_21", 6'd21, 1'b1);
    evalCheck("a_29", 6'd29, 1'b1);
    evalCheck("a_53", 6'd53, 1'b1);
    evalCheck("a_61", 6'd61, 1'b1);
    evalCheck("a_22", 6'd22, 1'b0);
    evalCheck("a_0", 6'd0, 1'b0);
    evalCheck("a_63", 6'd63, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd5);
    checkOutput("hold_after_63", 32'(eval_out), 32'd0);

    // Reset in the middle of a load, while eval_out is holding a 1.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, 6'd21);
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, 6'd29);
    checkOutput("pre_rst_eval", 32'(eval_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_ready", 32'(cfg_ready), 32'd0);
    checkOutput("midrst_loaded", 32'(tbl_loaded), 32'd0);
    checkOutput("midrst_eval_out", 32'(eval_out), 32'd0);
    checkOutput("midrst_eval_valid", 32'(eval_out_valid), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0);
    rst = 1'b0;
    evalCheck("midrst_tbl_21", 6'd21, 1'b0);

    // cfg_ready stays low in IDLE even with cfg_valid asserted.
    cfg_valid = 1'b1;
    #1;
    checkOutput("idle_ready_low", 32'(cfg_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 6'd0);

    // Same table with valid gaps.
    loadTable("gaps", TABLE_A, 1'b1);
    commitStep("gaps", 6'd29, 1'b0);
    evalCheck("g_29", 6'd29, 1'b1);
    evalCheck("g_53", 6'd53, 1'b1);
    evalCheck("g_22", 6'd22, 1'b0);
    evalCheck("g_62", 6'd62, 1'b0);

    // Abort: three beats, then a restart that loads all ones.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 6'd0);
    checkOutput("abort_no_error_yet", 32'(cfg_error), 32'd0);
    loadTable("abort", TABLE_ONE, 1'b0);
    checkOutput("abort_error_sticky", 32'(cfg_error), 32'd1);
    checkOutput("abort_no_done", 32'(cfg_done), 32'd0);
    commitStep("abort", 6'd5, 1'b0);
    evalCheck("abort_5", 6'd5, 1'b1);
    evalCheck("abort_0", 6'd0, 1'b1);

    // Commit race from an all-zero active table.
    doReset();
    loadTable("race", TABLE_ONE, 1'b0);
    commitStep("race", 6'd7, 1'b0);
    evalCheck("race_7_next", 6'd7, 1'b1);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

  // Backstop against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
